// File: rtl/tri_sched_pkg.sv
// Shared types and triangle RAM word layout for the raster-pass scheduler.
// Word = {color, vertex_a, vertex_b, vertex_c}, vertex = {x[9:0], y[9:0]}.
package tri_sched_pkg;

  localparam int COLOR_W = 24;
  localparam int VTX_W   = 20;
  localparam int TRI_W   = 3*VTX_W + COLOR_W;

  localparam int VC_LSB    = 0;
  localparam int VC_MSB    = VC_LSB + VTX_W - 1;
  localparam int VB_LSB    = VC_MSB + 1;
  localparam int VB_MSB    = VB_LSB + VTX_W - 1;
  localparam int VA_LSB    = VB_MSB + 1;
  localparam int VA_MSB    = VA_LSB + VTX_W - 1;
  localparam int COLOR_LSB = VA_MSB + 1;
  localparam int COLOR_MSB = COLOR_LSB + COLOR_W - 1;

  localparam int Y_LSB = 0;
  localparam int Y_MSB = 9;
  localparam int X_LSB = 10;
  localparam int X_MSB = 19;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_RASTER,
    S_DONE
  } state_e;

endpackage

// File: rtl/tri_degenerate.sv
// Flags a triangle whose vertices are not pairwise distinct.
// Such triangles cover no area and are skipped by the scheduler.
module tri_degenerate
  import tri_sched_pkg::*;
(
  input  logic [VTX_W-1:0] va_i,
  input  logic [VTX_W-1:0] vb_i,
  input  logic [VTX_W-1:0] vc_i,
  output logic             degen_o
);

  assign degen_o = (va_i == vb_i) ||
                   (vb_i == vc_i) ||
                   (va_i == vc_i);

endmodule

// File: rtl/triangle_scheduler.sv
// Per-frame raster sequencer: fetches triangles, issues them to the
// rasteriser one at a time and forwards coloured pixels downstream.
module triangle_scheduler
  import tri_sched_pkg::*;
#(
  parameter int TRIANGLES  = 72,
  parameter int ADDR_W     = $clog2(TRIANGLES),
  parameter int RD_LATENCY = 2
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               start_in,
  input  logic [ADDR_W:0]    tri_count_in,
  output logic [ADDR_W-1:0]  rd_addr_out,
  input  logic [TRI_W-1:0]   rd_data_in,
  output logic               rast_valid_out,
  output logic [VTX_W-1:0]   rast_vertex_a_out,
  output logic [VTX_W-1:0]   rast_vertex_b_out,
  output logic [VTX_W-1:0]   rast_vertex_c_out,
  input  logic               rast_pixel_valid_in,
  input  logic [VTX_W-1:0]   rast_pixel_in,
  input  logic               rast_last_in,
  output logic               pixel_valid_out,
  output logic [VTX_W-1:0]   pixel_out,
  output logic [COLOR_W-1:0] color_out,
  output logic               busy_out,
  output logic               frame_done_out
);

  localparam int WAIT_W = $clog2(RD_LATENCY + 1);
  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(TRIANGLES);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [COLOR_W-1:0]  col_q, col_d;
  logic [VTX_W-1:0]    va_q, va_d;
  logic [VTX_W-1:0]    vb_q, vb_d;
  logic [VTX_W-1:0]    vc_q, vc_d;
  logic [VTX_W-1:0]    oa_q, oa_d;
  logic [VTX_W-1:0]    ob_q, ob_d;
  logic [VTX_W-1:0]    oc_q, oc_d;
  logic                rv_q, rv_d;
  logic                pv_q, pv_d;
  logic [VTX_W-1:0]    pix_q, pix_d;
  logic [COLOR_W-1:0]  pcol_q, pcol_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                degen;
  logic                advance;
  logic                last_idx;
  logic [ADDR_W:0]     clamp_cnt;

  tri_degenerate u_degen (
    .va_i    (va_q),
    .vb_i    (vb_q),
    .vc_i    (vc_q),
    .degen_o (degen)
  );

  assign clamp_cnt = (tri_count_in > MAX_CNT) ? MAX_CNT : tri_count_in;
  assign last_idx  = ({1'b0, addr_q} == (cnt_q - 1'b1));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    col_d   = col_q;
    va_d    = va_q;
    vb_d    = vb_q;
    vc_d    = vc_q;
    oa_d    = oa_q;
    ob_d    = ob_q;
    oc_d    = oc_q;
    rv_d    = 1'b0;
    pv_d    = 1'b0;
    pix_d   = pix_q;
    pcol_d  = pcol_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    advance = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_in) begin
          cnt_d   = clamp_cnt;
          addr_d  = '0;
          busy_d  = 1'b1;
          wait_d  = WAIT_W'(RD_LATENCY);
          state_d = (clamp_cnt == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (wait_q <= WAIT_W'(1)) begin
          col_d   = rd_data_in[COLOR_MSB:COLOR_LSB];
          va_d    = rd_data_in[VA_MSB:VA_LSB];
          vb_d    = rd_data_in[VB_MSB:VB_LSB];
          vc_d    = rd_data_in[VC_MSB:VC_LSB];
          state_d = S_ISSUE;
        end else begin
          wait_d  = wait_q - 1'b1;
        end
      end
      S_ISSUE: begin
        oa_d = va_q;
        ob_d = vb_q;
        oc_d = vc_q;
        if (degen) begin
          advance = 1'b1;
        end else begin
          rv_d    = 1'b1;
          state_d = S_RASTER;
        end
      end
      S_RASTER: begin
        if (rast_pixel_valid_in) begin
          pv_d   = 1'b1;
          pix_d  = rast_pixel_in;
          pcol_d = col_q;
        end
        advance = rast_last_in;
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Shared by a finished raster and a skipped degenerate triangle
    if (advance) begin
      if (last_idx) begin
        state_d = S_DONE;
      end else begin
        addr_d  = addr_q + 1'b1;
        wait_d  = WAIT_W'(RD_LATENCY);
        state_d = S_FETCH;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      wait_q  <= '0;
      col_q   <= '0;
      va_q    <= '0;
      vb_q    <= '0;
      vc_q    <= '0;
      oa_q    <= '0;
      ob_q    <= '0;
      oc_q    <= '0;
      rv_q    <= 1'b0;
      pv_q    <= 1'b0;
      pix_q   <= '0;
      pcol_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      col_q   <= col_d;
      va_q    <= va_d;
      vb_q    <= vb_d;
      vc_q    <= vc_d;
      oa_q    <= oa_d;
      ob_q    <= ob_d;
      oc_q    <= oc_d;
      rv_q    <= rv_d;
      pv_q    <= pv_d;
      pix_q   <= pix_d;
      pcol_q  <= pcol_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign rd_addr_out       = addr_q;
  assign rast_valid_out    = rv_q;
  assign rast_vertex_a_out = oa_q;
  assign rast_vertex_b_out = ob_q;
  assign rast_vertex_c_out = oc_q;
  assign pixel_valid_out   = pv_q;
  assign pixel_out         = pix_q;
  assign color_out         = pcol_q;
  assign busy_out          = busy_q;
  assign frame_done_out    = done_q;

endmodule

// File: tb/tb_triangle_scheduler.sv
// Directed bench for triangle_scheduler: frame-level vector table plus
// hand sequences for timing, ignored inputs and mid-frame reset.
module tb_triangle_scheduler;
  import tri_sched_pkg::*;

  localparam int AW = 7;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              start_in;
  logic [AW:0]       tri_count_in;
  logic [AW-1:0]     rd_addr_out;
  logic [TRI_W-1:0]  rd_data_in;
  logic              rast_valid_out;
  logic [VTX_W-1:0]  va, vb, vc;
  logic              rast_pixel_valid_in;
  logic [VTX_W-1:0]  rast_pixel_in;
  logic              rast_last_in;
  logic              pixel_valid_out;
  logic [VTX_W-1:0]  pixel_out;
  logic [COLOR_W-1:0] color_out;
  logic              busy_out;
  logic              frame_done_out;

  logic [TRI_W-1:0]  ram [128];

  int errors = 0;
  int checks = 0;

  triangle_scheduler dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .start_in            (start_in),
    .tri_count_in        (tri_count_in),
    .rd_addr_out         (rd_addr_out),
    .rd_data_in          (rd_data_in),
    .rast_valid_out      (rast_valid_out),
    .rast_vertex_a_out   (va),
    .rast_vertex_b_out   (vb),
    .rast_vertex_c_out   (vc),
    .rast_pixel_valid_in (rast_pixel_valid_in),
    .rast_pixel_in       (rast_pixel_in),
    .rast_last_in        (rast_last_in),
    .pixel_valid_out     (pixel_valid_out),
    .pixel_out           (pixel_out),
    .color_out           (color_out),
    .busy_out            (busy_out),
    .frame_done_out      (frame_done_out)
  );

  always #5 clk_in = ~clk_in;

  // Synchronous RAM: data for the held address is present by the
  // second FETCH cycle and sampled on the final FETCH edge.
  always @(posedge clk_in) rd_data_in <= ram[rd_addr_out];

  function automatic logic [19:0] vtx(input int x, input int y);
    logic [19:0] v;
    v[X_MSB:X_LSB] = 10'(x);
    v[Y_MSB:Y_LSB] = 10'(y);
    return v;
  endfunction

  function automatic logic [TRI_W-1:0] mk_tri(input int i, input bit dg);
    logic [19:0] a, b, c;
    a = vtx(i, 1);
    b = dg ? a : vtx(i + 2, 1);
    c = vtx(i, 3);
    return {8'(i), 8'hA5, 8'(i + 1), a, b, c};
  endfunction

  task automatic fill_ram(input int dg);
    for (int i = 0; i < 128; i++) ram[i] = mk_tri(i, i == dg);
  endtask

  task automatic check(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return 128'({rd_addr_out, rast_valid_out, va, vb, vc, pixel_valid_out,
                 pixel_out, color_out, busy_out, frame_done_out});
  endfunction

  task automatic run_frame(input int cnt, output int issues,
                           output int first, output int last,
                           output int dones, output int vbad);
    issues = 0; first = -1; last = -1; dones = 0; vbad = 0;
    @(negedge clk_in);
    start_in = 1'b1;
    tri_count_in = 8'(cnt);
    for (int c = 0; c < 1500 && dones == 0; c++) begin
      @(negedge clk_in);
      start_in = 1'b0;
      rast_last_in = 1'b0;
      if (rast_valid_out) begin
        issues++;
        if (first < 0) first = int'(rd_addr_out);
        last = int'(rd_addr_out);
        if ({va, vb, vc} !== ram[rd_addr_out][VA_MSB:VC_LSB]) vbad++;
        rast_last_in = 1'b1;
      end
      if (frame_done_out) dones++;
    end
  endtask

  typedef struct {
    int cnt;
    int degen;
    int exp_issues;
    int exp_last;
  } vec_t;

  vec_t vt [6];

  initial begin
    int iss, fst, lst, dn, vbad, ph, lat, lastc, firstc;
    bit seen_done;

    vt[0] = '{1,   -1, 1,  0};
    vt[1] = '{3,    1, 2,  2};
    vt[2] = '{0,   -1, 0, -1};
    vt[3] = '{100, -1, 72, 71};
    vt[4] = '{5,   -1, 5,  4};
    vt[5] = '{72,  71, 71, 70};

    rst_in = 1'b0;
    start_in = 1'b0;
    tri_count_in = '0;
    rast_pixel_valid_in = 1'b0;
    rast_pixel_in = '0;
    rast_last_in = 1'b0;
    fill_ram(-1);

    repeat (2) @(negedge clk_in);
    check("reset_outputs", all_outs(), 128'(0));
    rst_in = 1'b1;
    @(negedge clk_in);

    // Single triangle: exact issue latency, pixel forwarding, done timing
    ram[0] = {24'hFF0000, vtx(10, 10), vtx(20, 10), vtx(10, 20)};
    start_in = 1'b1;
    tri_count_in = 8'd1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk_in);
      start_in = 1'b0;
      if (k == 1) check("t1_busy_high", 128'(busy_out), 128'(1));
      check($sformatf("t1_valid_k%0d", k), 128'(rast_valid_out),
            128'(k == 4));
    end
    check("t1_addr", 128'(rd_addr_out), 128'(0));
    check("t1_vertices", 128'({va, vb, vc}),
          128'({vtx(10, 10), vtx(20, 10), vtx(10, 20)}));
    rast_pixel_valid_in = 1'b1;
    rast_pixel_in = vtx(12, 12);
    @(negedge clk_in);
    check("t1_pix0", 128'({pixel_valid_out, pixel_out, color_out}),
          128'({1'b1, vtx(12, 12), 24'hFF0000}));
    rast_pixel_in = vtx(13, 12);
    rast_last_in = 1'b1;
    @(negedge clk_in);
    check("t1_pix_with_last", 128'({pixel_valid_out, pixel_out, color_out}),
          128'({1'b1, vtx(13, 12), 24'hFF0000}));
    check("t1_done_not_yet", 128'(frame_done_out), 128'(0));
    rast_pixel_valid_in = 1'b0;
    rast_last_in = 1'b0;
    @(negedge clk_in);
    check("t1_done_busy_pv", 128'({frame_done_out, busy_out, pixel_valid_out}),
          128'(3'b100));
    @(negedge clk_in);

    // Zero count with stray pixel/last inputs outside RASTER
    start_in = 1'b1;
    tri_count_in = 8'd0;
    rast_pixel_valid_in = 1'b1;
    rast_last_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    check("c0_k1", 128'({frame_done_out, busy_out, pixel_valid_out,
                         rast_valid_out}), 128'(4'b0100));
    @(negedge clk_in);
    check("c0_k2", 128'({frame_done_out, busy_out, pixel_valid_out,
                         rast_valid_out, rd_addr_out}), 128'({4'b1000, 7'd0}));
    rast_pixel_valid_in = 1'b0;
    rast_last_in = 1'b0;
    @(negedge clk_in);

    // Frame-level vector table
    foreach (vt[i]) begin
      fill_ram(vt[i].degen);
      run_frame(vt[i].cnt, iss, fst, lst, dn, vbad);
      check($sformatf("v%0d_issues", i), 128'(iss), 128'(vt[i].exp_issues));
      check($sformatf("v%0d_last_addr", i), 128'(lst), 128'(vt[i].exp_last));
      check($sformatf("v%0d_done", i), 128'(dn), 128'(1));
      check($sformatf("v%0d_vertices", i), 128'(vbad), 128'(0));
      check($sformatf("v%0d_busy_low", i), 128'(busy_out), 128'(0));
      @(negedge clk_in);
      check($sformatf("v%0d_done_1cyc", i), 128'(frame_done_out), 128'(0));
    end

    // start_in during RASTER and rast_last_in during FETCH are ignored
    fill_ram(-1);
    start_in = 1'b1;
    tri_count_in = 8'd3;
    iss = 0; ph = 0; lat = -1; lastc = -1; seen_done = 1'b0; firstc = -1;
    for (int c = 0; c < 300 && !seen_done; c++) begin
      @(negedge clk_in);
      start_in = 1'b0;
      rast_last_in = 1'b0;
      if (frame_done_out) seen_done = 1'b1;
      if (rast_valid_out) begin
        iss++;
        if (lastc >= 0 && lat < 0) lat = c - lastc;
        ph = 1;
      end else if (ph == 1) begin
        start_in = 1'b1;
        ph = 2;
      end else if (ph == 2) begin
        rast_last_in = 1'b1;
        if (lastc < 0) lastc = c;
        ph = 3;
      end else if (ph == 3) begin
        rast_last_in = 1'b1;
        ph = 0;
      end
    end
    check("ign_issues", 128'(iss), 128'(3));
    check("ign_last_to_issue", 128'(lat), 128'(4));
    check("ign_done", 128'(seen_done), 128'(1));
    check("ign_busy_low", 128'(busy_out), 128'(0));
    @(negedge clk_in);

    // Asynchronous reset while triangle 5 is rasterising
    start_in = 1'b1;
    tri_count_in = 8'd10;
    iss = 0;
    for (int c = 0; c < 300 && iss < 6; c++) begin
      @(negedge clk_in);
      start_in = 1'b0;
      rast_last_in = 1'b0;
      if (rast_valid_out) begin
        iss++;
        if (iss < 6) rast_last_in = 1'b1;
      end
    end
    check("rst_reached_tri5", 128'(rd_addr_out), 128'(5));
    #2 rst_in = 1'b0;
    #1 check("rst_async_outputs", all_outs(), 128'(0));
    @(negedge clk_in);
    check("rst_held_outputs", all_outs(), 128'(0));
    rst_in = 1'b1;
    run_frame(3, iss, fst, lst, dn, vbad);
    check("rst_restart_first", 128'(fst), 128'(0));
    check("rst_restart_issues", 128'(iss), 128'(3));
    check("rst_restart_done", 128'(dn), 128'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
